// File: rtl/vmcmp_seq.sv
// Sequencer for the vector mask-compare unit: walks one compare instruction
// beat by beat through the VRF and the compare unit, then forwards mask writes.
module vmcmp_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int VL_WIDTH   = 16,
  parameter int VRF_RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_vs1,
  input  logic [ADDR_WIDTH-1:0]   cmd_vs2,
  input  logic [ADDR_WIDTH-1:0]   cmd_vd,
  input  logic [VL_WIDTH-1:0]     cmd_vl,
  input  logic [1:0]              cmd_sew,
  input  logic [2:0]              cmd_opSel,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr0,
  output logic [ADDR_WIDTH-1:0]   rd_addr1,
  input  logic [DATA_WIDTH-1:0]   rd_data0,
  input  logic [DATA_WIDTH-1:0]   rd_data1,
  output logic                    cmp_valid,
  output logic [DATA_WIDTH-1:0]   cmp_vec0,
  output logic [DATA_WIDTH-1:0]   cmp_vec1,
  output logic [1:0]              cmp_sew,
  output logic [2:0]              cmp_opSel,
  output logic [7:0]              cmp_start_idx,
  output logic                    cmp_req_start,
  output logic                    cmp_req_end,
  output logic [ADDR_WIDTH-1:0]   cmp_addr,
  input  logic                    cmp_out_valid,
  input  logic [ADDR_WIDTH-1:0]   cmp_out_addr,
  input  logic [DATA_WIDTH-1:0]   cmp_out_vec,
  input  logic [DATA_WIDTH/8-1:0] cmp_out_be,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    busy,
  output logic                    done
);

  localparam int LOG2DW = $clog2(DATA_WIDTH);
  localparam int CW     = VL_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0]   r_vs1, r_vs2, r_vd;
  logic [1:0]              r_sew;
  logic [2:0]              r_op;
  logic [CW-1:0]           r_beats, r_words, r_epb, r_b, r_w, r_eoff;
  logic                    r_done;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH/8-1:0] r_wr_be;

  logic                    r_mv    [VRF_RD_LAT];
  logic [7:0]              r_msidx [VRF_RD_LAT];
  logic [ADDR_WIDTH-1:0]   r_maddr [VRF_RD_LAT];
  logic                    r_mst   [VRF_RD_LAT];
  logic                    r_mend  [VRF_RD_LAT];

  logic                    w_acc, w_issue, w_last, w_wr_fire;
  logic [7:0]              w_lgepb;
  logic [CW-1:0]           w_epb, w_beats, w_words;
  logic [7:0]              w_sidx;
  logic [ADDR_WIDTH-1:0]   w_maddr;

  assign w_acc     = cmd_valid && (r_state == IDLE);
  assign w_issue   = (r_state == ISSUE);
  assign w_last    = (r_b == r_beats - CW'(1));
  assign w_wr_fire = cmp_out_valid && (r_state != IDLE);

  // Elements per beat is a power of two, so the ceil divisions reduce to shifts.
  assign w_lgepb = 8'(LOG2DW - 3) - {6'd0, cmd_sew};
  assign w_epb   = CW'(1) << w_lgepb;
  assign w_beats = (CW'(cmd_vl) + w_epb - CW'(1)) >> w_lgepb;
  assign w_words = (CW'(cmd_vl) + CW'(DATA_WIDTH - 1)) >> LOG2DW;

  // r_eoff tracks b*epb incrementally, giving bit offset and mask word without a multiplier.
  assign w_sidx  = 8'(r_eoff[LOG2DW-1:0]);
  assign w_maddr = r_vd + ADDR_WIDTH'(r_eoff >> LOG2DW);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = (cmd_vl == '0) ? DONE : ISSUE;
      ISSUE:   if (w_last) w_next = DRAIN;
      DRAIN:   if (r_w == r_words) w_next = DONE;
      DONE:    if (r_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vd      <= '0;
      r_sew     <= '0;
      r_op      <= '0;
      r_beats   <= '0;
      r_words   <= '0;
      r_epb     <= '0;
      r_b       <= '0;
      r_w       <= '0;
      r_eoff    <= '0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_be   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_vs1   <= cmd_vs1;
        r_vs2   <= cmd_vs2;
        r_vd    <= cmd_vd;
        r_sew   <= cmd_sew;
        r_op    <= cmd_opSel;
        r_beats <= w_beats;
        r_words <= w_words;
        r_epb   <= w_epb;
        r_b     <= '0;
        r_w     <= '0;
        r_eoff  <= '0;
      end else begin
        if (w_issue) begin
          r_b    <= r_b + CW'(1);
          r_eoff <= r_eoff + r_epb;
        end
        if (r_wr_en) r_w <= r_w + CW'(1);
      end
      // Done is held off one cycle inside DONE so cmd_ready rises only after the pulse.
      r_done    <= (r_state == DONE) && !r_done;
      r_wr_en   <= w_wr_fire;
      r_wr_addr <= w_wr_fire ? cmp_out_addr : '0;
      r_wr_data <= w_wr_fire ? cmp_out_vec  : '0;
      r_wr_be   <= w_wr_fire ? cmp_out_be   : '0;
    end
  end

  // Beat metadata travels alongside the VRF read so it meets its data at the compare unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VRF_RD_LAT; i++) begin
        r_mv[i]    <= 1'b0;
        r_msidx[i] <= '0;
        r_maddr[i] <= '0;
        r_mst[i]   <= 1'b0;
        r_mend[i]  <= 1'b0;
      end
    end else begin
      r_mv[0]    <= w_issue;
      r_msidx[0] <= w_issue ? w_sidx : '0;
      r_maddr[0] <= w_issue ? w_maddr : '0;
      r_mst[0]   <= w_issue && (r_b == '0);
      r_mend[0]  <= w_issue && w_last;
      for (int i = 1; i < VRF_RD_LAT; i++) begin
        r_mv[i]    <= r_mv[i-1];
        r_msidx[i] <= r_msidx[i-1];
        r_maddr[i] <= r_maddr[i-1];
        r_mst[i]   <= r_mst[i-1];
        r_mend[i]  <= r_mend[i-1];
      end
    end
  end

  assign cmd_ready     = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign rd_en         = w_issue;
  assign rd_addr0      = w_issue ? r_vs1 + ADDR_WIDTH'(r_b) : '0;
  assign rd_addr1      = w_issue ? r_vs2 + ADDR_WIDTH'(r_b) : '0;
  assign cmp_valid     = r_mv[VRF_RD_LAT-1];
  assign cmp_vec0      = cmp_valid ? rd_data0 : '0;
  assign cmp_vec1      = cmp_valid ? rd_data1 : '0;
  assign cmp_sew       = cmp_valid ? r_sew : '0;
  assign cmp_opSel     = cmp_valid ? r_op : '0;
  assign cmp_start_idx = r_msidx[VRF_RD_LAT-1];
  assign cmp_req_start = r_mst[VRF_RD_LAT-1];
  assign cmp_req_end   = r_mend[VRF_RD_LAT-1];
  assign cmp_addr      = r_maddr[VRF_RD_LAT-1];
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign wr_be         = r_wr_be;

endmodule
